// File: rtl/tile_config_dispatcher_pkg.sv
// Shared types and constants for the tile-select bus dispatcher.
// Error codes, FSM state encoding and the id-validity helper live here.
package tile_pkg;

    localparam int ID_W   = 8;
    localparam int DATA_W = 32;

    localparam logic [ID_W-1:0] IDLE_ID = 8'h00;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_BADID = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Ids at or below the reserved value are never addressed on the bus.
    function automatic logic id_is_valid(input logic [ID_W-1:0] id,
                                         input logic [ID_W-1:0] reserved);
        return id > reserved;
    endfunction

endpackage

// File: rtl/tile_config_dispatcher_if.sv
// Bundle of host request, tile broadcast and completion signals for the dispatcher.
// Request handshake: a request transfers on a rising clk edge where req_valid && req_ready;
// req_id/req_data must be stable while req_valid is high, and req_ready never depends on req_valid.
interface tile_config_dispatcher_if #(
    parameter int ID_W   = 8,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ID_W-1:0]   req_id;
    logic [DATA_W-1:0] req_data;
    logic [ID_W-1:0]   caller_id;
    logic [DATA_W-1:0] bus_data;
    logic              tile_ack;
    logic              done_valid;
    logic [1:0]        done_err;
    logic [ID_W-1:0]   done_id;
    logic              busy;

    modport master (
        input  req_valid, req_id, req_data, tile_ack,
        output req_ready, caller_id, bus_data, done_valid, done_err, done_id, busy
    );

    modport slave (
        output req_valid, req_id, req_data, tile_ack,
        input  req_ready, caller_id, bus_data, done_valid, done_err, done_id, busy
    );

endinterface

// File: rtl/tile_config_dispatcher_fifo.sv
// Synchronous request FIFO with first-word-fall-through read data.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module tile_req_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         wr_en;
    logic         rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/tile_config_dispatcher.sv
// Initiator on the tile-select bus: queues config requests and broadcasts one target at a time,
// holding caller_id/bus_data until the addressed tile's write strobe comes back as tile_ack.
module tile_config_dispatcher
    import tile_pkg::*;
#(
    parameter int              ID_W        = tile_pkg::ID_W,
    parameter int              DATA_W      = tile_pkg::DATA_W,
    parameter int              DEPTH       = 4,
    parameter logic [ID_W-1:0] RESERVED_ID = 8'h00,
    parameter int              TIMEOUT     = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    tile_config_dispatcher_if.master bus,
    output state_t                  dbg_state
);
    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [ID_W-1:0] BUS_IDLE = RESERVED_ID;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic [ID_W+DATA_W-1:0] fifo_rdata;
    logic [ID_W-1:0]        head_id;
    logic [DATA_W-1:0]      head_data;

    state_t                 state_q;
    state_t                 state_d;
    logic [ID_W-1:0]        hold_id;
    logic [DATA_W-1:0]      hold_data;
    logic [CNT_W-1:0]       wait_cnt;
    logic [ID_W-1:0]        caller_q;
    logic [DATA_W-1:0]      bus_data_q;
    logic [1:0]             done_err_q;
    logic [ID_W-1:0]        done_id_q;

    logic                   load_bus;
    logic                   enter_resp;
    logic [1:0]             resp_err;

    assign fifo_push = bus.req_valid && !fifo_full;
    assign {head_id, head_data} = fifo_rdata;

    tile_req_fifo #(
        .W     (ID_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({bus.req_id, bus.req_data}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        fifo_pop   = 1'b0;
        load_bus   = 1'b0;
        enter_resp = 1'b0;
        resp_err   = ERR_OK;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!id_is_valid(hold_id, RESERVED_ID)) begin
                    enter_resp = 1'b1;
                    resp_err   = ERR_BADID;
                    state_d    = ST_RESP;
                end else begin
                    load_bus = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // An ack arriving on the last counted cycle still completes as ok.
                if (bus.tile_ack) begin
                    enter_resp = 1'b1;
                    resp_err   = ERR_OK;
                    state_d    = ST_RESP;
                end else if (wait_cnt == CNT_MAX) begin
                    enter_resp = 1'b1;
                    resp_err   = ERR_TMO;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_id    <= '0;
            hold_data  <= '0;
            wait_cnt   <= '0;
            caller_q   <= BUS_IDLE;
            bus_data_q <= '0;
            done_err_q <= ERR_OK;
            done_id_q  <= '0;
        end else begin
            state_q <= state_d;
            if (fifo_pop) begin
                hold_id   <= head_id;
                hold_data <= head_data;
            end
            if (load_bus) begin
                caller_q   <= hold_id;
                bus_data_q <= hold_data;
                wait_cnt   <= '0;
            end else if (state_q == ST_WAIT && wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            // Dropping caller_id on the way into RESP caps a tile's strobe at two cycles.
            if (enter_resp) begin
                caller_q   <= BUS_IDLE;
                bus_data_q <= '0;
                done_err_q <= resp_err;
                done_id_q  <= hold_id;
            end
        end
    end

    assign bus.req_ready  = !fifo_full;
    assign bus.caller_id  = caller_q;
    assign bus.bus_data   = bus_data_q;
    assign bus.done_valid = (state_q == ST_RESP);
    assign bus.done_err   = done_err_q;
    assign bus.done_id    = done_id_q;
    assign bus.busy       = (state_q != ST_IDLE) || !fifo_empty;
    assign dbg_state      = state_q;

endmodule
